hash_msg_packer: RTL and testbench

//  Packs a byte stream (valid/ready) into one 64-bit word plus byte count for the hasher stage.

---
 rtl/hash_msg_packer_if.sv | 33 +++
 rtl/hash_msg_packer.sv | 106 ++++++++++
 tb/tb_hash_msg_packer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hash_msg_packer_if.sv
// Byte-stream in / packed-word out bundle between a byte source, the packer and the hasher.
// Latency: n/a (wiring only).
// Backpressure: in_ready gates the byte side; out_ready gates the word side.
// Ports (slave = packer view):
//   in_byte/in_valid/in_last/flush  -> packer     in_ready  <- packer
//   data/data_len/out_last/out_valid <- packer    out_ready -> packer
interface hash_msg_packer_if #(
    parameter int MAX_BYTES = 8,
    parameter int LEN_W     = 4
);
    logic [7:0]             in_byte;
    logic                   in_valid;
    logic                   in_last;
    logic                   flush;
    logic                   in_ready;
    logic [8*MAX_BYTES-1:0] data;
    logic [LEN_W-1:0]       data_len;
    logic                   out_last;
    logic                   out_valid;
    logic                   out_ready;

    // Environment side: drives bytes in and consumes words.
    modport master (
        output in_byte, in_valid, in_last, flush, out_ready,
        input  in_ready, data, data_len, out_last, out_valid
    );

    // Packer side.
    modport slave (
        input  in_byte, in_valid, in_last, flush, out_ready,
        output in_ready, data, data_len, out_last, out_valid
    );
endinterface

// File: rtl/hash_msg_packer.sv
// Packs a byte stream into one 64-bit word + byte count for the hasher.
// Latency: word valid the cycle after the closing byte / flush is sampled.
// Backpressure: in_ready=0 while a word is held; word held stable until out_ready.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-high; drops any partial message
//   bus    - hash_msg_packer_if.slave (byte input, packed word output)
module hash_msg_packer #(
    parameter int MAX_BYTES = 8,
    parameter int LEN_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    hash_msg_packer_if.slave   bus
);
    localparam int IDX_W = $clog2(MAX_BYTES);
    localparam int DW    = 8 * MAX_BYTES;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q,     state_d;
    logic [DW-1:0]    data_q,      data_d;
    logic [LEN_W-1:0] count_q,     count_d;
    logic             out_last_q,  out_last_d;
    logic             out_valid_q, out_valid_d;

    logic             in_ready_w;
    logic             accept;
    logic [IDX_W+2:0] byte_ofs;

    assign in_ready_w = (state_q != FULL);
    assign accept     = bus.in_valid & in_ready_w;
    // Bit offset of the next free byte lane. count_q < MAX_BYTES whenever
    // a byte can be accepted, so the low IDX_W bits are sufficient.
    assign byte_ofs   = {count_q[IDX_W-1:0], 3'b000};

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        count_d     = count_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;

        case (state_q)
            EMPTY, FILL: begin
                if (accept) begin
                    data_d[byte_ofs +: 8] = bus.in_byte;
                    count_d               = count_q + LEN_W'(1);
                end
                // The byte (if any) is stored before the word closes, so a
                // byte+flush or a last byte that fills the word both land in it.
                if ((accept && (bus.in_last || count_d == LEN_W'(MAX_BYTES))) || bus.flush) begin
                    state_d     = FULL;
                    out_valid_d = 1'b1;
                    // A word that closes only because it filled up is a chunk
                    // of a continuing message.
                    out_last_d  = bus.flush | (accept & bus.in_last);
                end else begin
                    state_d = (count_d == '0) ? EMPTY : FILL;
                end
            end
            FULL: begin
                if (bus.out_ready) begin
                    state_d     = EMPTY;
                    data_d      = '0;
                    count_d     = '0;
                    out_last_d  = 1'b0;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = EMPTY;
                data_d      = '0;
                count_d     = '0;
                out_last_d  = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            data_q      <= '0;
            count_q     <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            count_q     <= count_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.data      = data_q;
    assign bus.data_len  = count_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_hash_msg_packer.sv
// Scoreboard bench for hash_msg_packer: directed byte streams, expected words queued at issue time.
// Latency: checks word appears the cycle after the closing byte.
// Backpressure: exercises held words with out_ready=0 and in_valid asserted.
module tb_hash_msg_packer;
    typedef struct packed {
        logic [63:0] d;
        logic [3:0]  l;
        logic        last;
    } exp_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_bad;
    exp_t sb[$];

    hash_msg_packer_if #(.MAX_BYTES(8), .LEN_W(4)) bus ();

    hash_msg_packer #(.MAX_BYTES(8), .LEN_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every consumed word is popped from the scoreboard and compared.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_word: got data=%h len=%0d last=%0d expected none",
                             bus.data, bus.data_len, bus.out_last);
                end else begin
                    e = sb.pop_front();
                    chk("word_data", bus.data, e.d);
                    chk("word_len",  64'(bus.data_len), 64'(e.l));
                    chk("word_last", 64'(bus.out_last), 64'(e.last));
                end
            end
        end
    end

    function automatic exp_t mk(input logic [63:0] d, input logic [3:0] l, input logic last);
        exp_t e;
        e.d = d; e.l = l; e.last = last;
        return e;
    endfunction

    // Present one beat and hold it until the packer takes it. Starts and ends
    // just after a rising edge.
    task automatic drive(input logic v, input logic [7:0] b, input logic last, input logic fl);
        bit ok;
        ok = 0;
        bus.in_valid = v;
        bus.in_byte  = b;
        bus.in_last  = last;
        bus.flush    = fl;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout: got in_ready=0 for 50 cycles expected 1");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        drive(1'b1, b, last, 1'b0);
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                ok = 1;
                break;
            end
        end
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL drain_timeout: got %0d words pending expected 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.in_byte   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        #1;
        chk("rst_data",      bus.data, 64'h0);
        chk("rst_len",       64'(bus.data_len), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_last",  64'(bus.out_last), 64'd0);
        chk("rst_in_ready",  64'(bus.in_ready), 64'd1);
        #21;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 1: three-byte message, word one cycle after the last byte
        sb.push_back(mk(64'h0000_0000_00CC_BBAA, 4'd3, 1'b1));
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b1);
        @(negedge clk);
        chk("t1_latency_valid", 64'(bus.out_valid), 64'd1);
        @(negedge clk);
        chk("t1_valid_drops", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        drain();

        // 2: ten bytes split into a full chunk and a tail
        sb.push_back(mk(64'h0807_0605_0403_0201, 4'd8, 1'b0));
        sb.push_back(mk(64'h0000_0000_0000_0A09, 4'd2, 1'b1));
        for (int i = 1; i <= 10; i++) send_byte(8'(i), (i == 10));
        drain();

        // 3: flush in EMPTY gives a zero-length message
        sb.push_back(mk(64'h0, 4'd0, 1'b1));
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        drain();
        @(negedge clk);
        chk("t3_in_ready", 64'(bus.in_ready), 64'd1);
        chk("t3_idle",     64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;

        // 4: held word under backpressure while the source keeps offering a byte
        bus.out_ready = 1'b0;
        sb.push_back(mk(64'h5A, 4'd1, 1'b1));
        send_byte(8'h5A, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'h55;
        bus.in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_data",  bus.data, 64'h5A);
            chk("t4_hold_len",   64'(bus.data_len), 64'd1);
            chk("t4_hold_last",  64'(bus.out_last), 64'd1);
            chk("t4_hold_valid", 64'(bus.out_valid), 64'd1);
            chk("t4_in_ready",   64'(bus.in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t4_in_ready_back", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        // A zero-length flush proves the offered 0x55 never got in.
        sb.push_back(mk(64'h0, 4'd0, 1'b1));
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        drain();

        // 5: asynchronous reset mid-message
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        chk("t5_rst_data",  bus.data, 64'h0);
        chk("t5_rst_len",   64'(bus.data_len), 64'd0);
        chk("t5_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("t5_rst_ready", 64'(bus.in_ready), 64'd1);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        sb.push_back(mk(64'h33, 4'd1, 1'b1));
        send_byte(8'h33, 1'b1);
        drain();

        // 6: byte and flush in the same cycle
        sb.push_back(mk(64'h2211, 4'd2, 1'b1));
        send_byte(8'h11, 1'b0);
        drive(1'b1, 8'h22, 1'b0, 1'b1);
        drain();

        // 7: exactly eight bytes ending on in_last, no trailing empty word
        sb.push_back(mk(64'hF7F6_F5F4_F3F2_F1F0, 4'd8, 1'b1));
        for (int i = 0; i < 8; i++) send_byte(8'(8'hF0 + i), (i == 7));
        drain();
        repeat (4) @(negedge clk);
        chk("t7_no_extra_word", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;

        // 8: flush alone closes a partial message
        sb.push_back(mk(64'h44, 4'd1, 1'b1));
        send_byte(8'h44, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
